// File: rtl/pci_master_seq_if.sv
// rtl/pci_master_seq_if.sv - PCI core user-side bus between the sequencer and the core
interface pci_master_seq_if;
    logic [31:0] adio_out;
    logic        m_data;
    logic        m_data_vld;
    logic        m_addr_n;
    logic [39:0] csr;
    logic [31:0] adio_in;
    logic [3:0]  m_cbe;
    logic        m_wrdn;
    logic        request;
    logic        requesthold;
    logic        complete;
    logic        m_ready;

    modport master (
        input  adio_out, m_data, m_data_vld, m_addr_n, csr,
        output adio_in, m_cbe, m_wrdn, request, requesthold, complete, m_ready
    );

    modport slave (
        output adio_out, m_data, m_data_vld, m_addr_n, csr,
        input  adio_in, m_cbe, m_wrdn, request, requesthold, complete, m_ready
    );
endinterface

// File: rtl/pci_master_seq.sv
// rtl/pci_master_seq.sv - PCI initiator sequencer: burst read/write with retry, abort and auto-start
module pci_master_seq #(
    parameter int          MAX_LEN     = 16,
    parameter int          RETRY_MAX   = 8,
    parameter int          START_DELAY = 31,
    parameter logic [31:0] AUTO_ADDR   = 32'h0000_1000,
    parameter logic [31:0] WDATA_SEED  = 32'hA5A5_0000
) (
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic                      cmd_dir,
    input  logic [31:0]               cmd_addr,
    input  logic [$clog2(MAX_LEN):0]  cmd_len,
    input  logic                      clr,
    pci_master_seq_if.master          bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [31:0]               rd_data,
    output logic                      rd_valid,
    output logic [$clog2(MAX_LEN):0]  beats_done,
    output logic [7:0]                retry_cnt
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    typedef enum logic [2:0] {IDLE, REQ, XFER, RTY, DONE, DEAD} state_t;

    state_t          state, state_nxt;
    logic [1:0]      err_nxt;
    logic            dir;
    logic [31:0]     addr;
    logic [LW-1:0]   len;
    logic [LW-1:0]   len_in;
    logic [15:0]     delay_cnt;
    logic            auto_armed;
    logic            ready_q;
    logic            m_data_q;
    logic            m_data_fell;
    logic            fatal_f;
    logic            retry_f;
    logic            complete_q;
    logic            start_go;
    logic            start_auto;
    logic [31:0]     cur_addr;
    logic            unused_bits;

    assign unused_bits = ^{bus.csr[37], bus.csr[35:0], cmd_addr[1:0]};

    assign m_data_fell = ~bus.m_data & m_data_q;
    assign start_go    = (state == IDLE) && go;
    assign start_auto  = (state == IDLE) && auto_armed && (delay_cnt == 16'd0);
    assign cur_addr    = addr + 32'({beats_done, 2'b00});

    always_comb begin
        len_in = cmd_len;
        if (cmd_len == '0)
            len_in = LW'(1);
        else if (cmd_len > LW'(MAX_LEN))
            len_in = LW'(MAX_LEN);
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        unique case (state)
            IDLE: if (start_go || start_auto) state_nxt = REQ;
            REQ:  state_nxt = XFER;
            XFER: begin
                if (m_data_fell) begin
                    if (fatal_f) begin
                        state_nxt = DEAD;
                        err_nxt   = 2'b01;
                    end else if (beats_done == len) begin
                        state_nxt = DONE;
                    end else if (retry_f && (retry_cnt == 8'(RETRY_MAX))) begin
                        state_nxt = DEAD;
                        err_nxt   = 2'b10;
                    end else begin
                        state_nxt = RTY;
                    end
                end
            end
            RTY:  state_nxt = REQ;
            DONE: state_nxt = IDLE;
            DEAD: if (clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state      <= IDLE;
            err_code   <= 2'b00;
            dir        <= 1'b0;
            addr       <= 32'd0;
            len        <= '0;
            beats_done <= '0;
            retry_cnt  <= 8'd0;
            delay_cnt  <= 16'(START_DELAY);
            auto_armed <= (START_DELAY != 0);
            ready_q    <= 1'b0;
            m_data_q   <= 1'b0;
            fatal_f    <= 1'b0;
            retry_f    <= 1'b0;
            rd_data    <= 32'd0;
            rd_valid   <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            ready_q  <= 1'b1;
            m_data_q <= bus.m_data;
            rd_valid <= 1'b0;

            // The delay only starts counting once the core has seen m_ready.
            if (ready_q && (delay_cnt != 16'd0))
                delay_cnt <= delay_cnt - 16'd1;
            if (start_auto)
                auto_armed <= 1'b0;

            if (start_go) begin
                dir        <= cmd_dir;
                addr       <= {cmd_addr[31:2], 2'b00};
                len        <= len_in;
                beats_done <= '0;
                retry_cnt  <= 8'd0;
                err_code   <= 2'b00;
            end else if (start_auto) begin
                dir        <= 1'b0;
                addr       <= {AUTO_ADDR[31:2], 2'b00};
                len        <= LW'(1);
                beats_done <= '0;
                retry_cnt  <= 8'd0;
                err_code   <= 2'b00;
            end

            if ((state == XFER) && bus.m_data_vld) begin
                if (beats_done != len)
                    beats_done <= beats_done + LW'(1);
                if (!dir) begin
                    rd_data  <= bus.adio_out;
                    rd_valid <= 1'b1;
                end
            end

            if ((state == RTY) && (retry_cnt != 8'hFF))
                retry_cnt <= retry_cnt + 8'd1;

            if (!bus.m_addr_n) begin
                fatal_f <= 1'b0;
                retry_f <= 1'b0;
            end else if (bus.m_data) begin
                fatal_f <= bus.csr[39] | bus.csr[38];
                retry_f <= bus.csr[36];
            end

            complete_q <= ((state == REQ) || (state == XFER)) && ((len - beats_done) <= LW'(1));
        end
    end

    always_comb begin
        bus.adio_in = 32'd0;
        bus.m_cbe   = 4'b0000;
        if (!bus.m_addr_n) begin
            bus.adio_in = cur_addr;
            bus.m_cbe   = {3'b011, dir};
        end else if (dir && bus.m_data) begin
            bus.adio_in = WDATA_SEED + 32'(beats_done);
        end
    end

    assign bus.m_wrdn      = dir;
    assign bus.request     = (state == REQ);
    assign bus.requesthold = 1'b0;
    assign bus.complete    = complete_q;
    assign bus.m_ready     = ready_q;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign error           = (state == DEAD);
endmodule

// File: tb/tb_pci_master_seq.sv
// tb/tb_pci_master_seq.sv - directed self-checking bench for pci_master_seq
module tb_pci_master_seq;
    logic        CLK;
    logic        reset_n;
    logic        go;
    logic        cmd_dir;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic        clr;
    logic        busy, done, error, rd_valid;
    logic [1:0]  err_code;
    logic [31:0] rd_data;
    logic [4:0]  beats_done;
    logic [7:0]  retry_cnt;

    pci_master_seq_if bus_if ();

    pci_master_seq #(
        .MAX_LEN(16), .RETRY_MAX(2), .START_DELAY(31),
        .AUTO_ADDR(32'h0000_1000), .WDATA_SEED(32'hA5A5_0000)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .go(go), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .clr(clr), .bus(bus_if),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .rd_data(rd_data), .rd_valid(rd_valid), .beats_done(beats_done),
        .retry_cnt(retry_cnt)
    );

    localparam logic [39:0] CSR_RETRY = 40'h10_0000_0000;
    localparam logic [39:0] CSR_FATAL = 40'h40_0000_0000;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          rdv_cnt = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wq[$];
    logic [31:0] addr_seen;
    logic [3:0]  cbe_seen;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1) begin
            rdv_cnt++;
            rd_q.push_back(rd_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic issue(input logic d, input logic [31:0] a, input logic [4:0] l);
        go = 1'b1; cmd_dir = d; cmd_addr = a; cmd_len = l;
        cyc();
        go = 1'b0;
    endtask

    // Core-side model of one bus attempt, entered while request is high.
    task automatic attempt(input int nbeats, input logic [39:0] csr_val, input logic [31:0] rd_base);
        int ncyc;
        ncyc = (nbeats > 0) ? nbeats : 1;
        cyc();
        bus_if.m_addr_n = 1'b0;
        #1;
        addr_seen = bus_if.adio_in;
        cbe_seen  = bus_if.m_cbe;
        cyc();
        bus_if.m_addr_n = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            bus_if.m_data     = 1'b1;
            bus_if.m_data_vld = (i < nbeats);
            bus_if.adio_out   = rd_base + 32'(i);
            bus_if.csr        = csr_val;
            #1;
            if (i < nbeats) wq.push_back(bus_if.adio_in);
            cyc();
        end
        bus_if.m_data = 1'b0; bus_if.m_data_vld = 1'b0;
        bus_if.csr = 40'd0; bus_if.adio_out = 32'd0;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(); cyc();
        checks++;
        if ({busy, done, error, err_code, rd_valid, beats_done, retry_cnt} !== 20'd0) begin
            failures++;
            $display("FAIL reset_status: got %h required 0",
                     {busy, done, error, err_code, rd_valid, beats_done, retry_cnt});
        end
        checks++;
        if ({bus_if.adio_in, bus_if.m_cbe, bus_if.m_wrdn, bus_if.request, bus_if.requesthold,
             bus_if.complete, bus_if.m_ready} !== 42'd0) begin
            failures++;
            $display("FAIL reset_bus: got %h required 0",
                     {bus_if.adio_in, bus_if.m_cbe, bus_if.m_wrdn, bus_if.request,
                      bus_if.requesthold, bus_if.complete, bus_if.m_ready});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_auto_start();
        int n;
        n = 0;
        while (bus_if.request !== 1'b1 && n < 40) begin
            cyc();
            n++;
            if (n == 1) begin
                checks++;
                if (bus_if.m_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL m_ready_after_first: got %b required 1", bus_if.m_ready);
                end
            end
        end
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL auto_start_cycle: got %0d required 33", n);
        end
        if (n < 40) begin
            rd_q.delete();
            attempt(1, 40'd0, 32'hCAFE_0000);
            checks++;
            if (addr_seen !== 32'h0000_1000 || cbe_seen !== 4'b0110) begin
                failures++;
                $display("FAIL auto_addr_phase: got %h/%b required 00001000/0110", addr_seen, cbe_seen);
            end
            checks++;
            if (done !== 1'b1 || rd_data !== 32'hCAFE_0000) begin
                failures++;
                $display("FAIL auto_done: got done=%b rd_data=%h required 1/cafe0000", done, rd_data);
            end
        end
        cyc();
    endtask

    task automatic test_write_burst();
        int d0;
        d0 = done_cnt;
        wq.delete();
        issue(1'b1, 32'h0000_2000, 5'd4);
        checks++;
        if (bus_if.request !== 1'b1) begin
            failures++;
            $display("FAIL wr_request: got %b required 1", bus_if.request);
        end
        attempt(4, 40'd0, 32'd0);
        checks++;
        if (addr_seen !== 32'h0000_2000 || cbe_seen !== 4'b0111) begin
            failures++;
            $display("FAIL wr_addr_phase: got %h/%b required 00002000/0111", addr_seen, cbe_seen);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wq.size() <= i || wq[i] !== 32'hA5A5_0000 + 32'(i)) begin
                failures++;
                $display("FAIL wr_data%0d: got %h required %h", i,
                         (wq.size() > i) ? wq[i] : 32'hx, 32'hA5A5_0000 + 32'(i));
            end
        end
        checks++;
        if (beats_done !== 5'd4 || bus_if.m_wrdn !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL wr_end: got beats=%0d wrdn=%b done=%b required 4/1/1",
                     beats_done, bus_if.m_wrdn, done);
        end
        cyc();
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_done_once: got pulses=%0d busy=%b required 1/0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_disconnect();
        int r0;
        r0 = rdv_cnt;
        rd_q.delete();
        issue(1'b0, 32'h0000_2000, 5'd8);
        attempt(3, CSR_RETRY, 32'h0000_1000);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || bus_if.request !== 1'b0) begin
            failures++;
            $display("FAIL disc_rty: got busy=%b done=%b req=%b required 1/0/0",
                     busy, done, bus_if.request);
        end
        cyc();
        checks++;
        if (bus_if.request !== 1'b1 || retry_cnt !== 8'd1) begin
            failures++;
            $display("FAIL disc_rerequest: got req=%b retry_cnt=%0d required 1/1",
                     bus_if.request, retry_cnt);
        end
        attempt(5, 40'd0, 32'h0000_1003);
        checks++;
        if (addr_seen !== 32'h0000_200C) begin
            failures++;
            $display("FAIL disc_resume_addr: got %h required 0000200c", addr_seen);
        end
        checks++;
        if (done !== 1'b1 || beats_done !== 5'd8) begin
            failures++;
            $display("FAIL disc_done: got done=%b beats=%0d required 1/8", done, beats_done);
        end
        cyc();
        checks++;
        if (rdv_cnt - r0 != 8) begin
            failures++;
            $display("FAIL disc_rd_valid: got %0d required 8", rdv_cnt - r0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_q.size() <= i || rd_q[i] !== 32'h0000_1000 + 32'(i)) begin
                failures++;
                $display("FAIL disc_rd_data%0d: got %h required %h", i,
                         (rd_q.size() > i) ? rd_q[i] : 32'hx, 32'h0000_1000 + 32'(i));
            end
        end
    endtask

    task automatic test_retry_limit();
        int d0;
        d0 = done_cnt;
        issue(1'b0, 32'h0000_3000, 5'd2);
        for (int k = 0; k < 3; k++) begin
            attempt(0, CSR_RETRY, 32'd0);
            if (k < 2) begin
                cyc();
                checks++;
                if (bus_if.request !== 1'b1 || error !== 1'b0) begin
                    failures++;
                    $display("FAIL rl_retry%0d: got req=%b error=%b required 1/0", k, bus_if.request, error);
                end
            end
        end
        checks++;
        if (error !== 1'b1 || err_code !== 2'b10 || retry_cnt !== 8'd2) begin
            failures++;
            $display("FAIL rl_dead: got error=%b err_code=%b retry_cnt=%0d required 1/10/2",
                     error, err_code, retry_cnt);
        end
        cyc(); cyc(); cyc();
        checks++;
        if (error !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL rl_hold: got error=%b done_pulses=%0d required 1/0", error, done_cnt - d0);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rl_clr: got error=%b busy=%b required 0/0", error, busy);
        end
    endtask

    task automatic test_fatal();
        issue(1'b1, 32'h0000_4000, 5'd4);
        attempt(2, CSR_FATAL, 32'd0);
        checks++;
        if (error !== 1'b1 || err_code !== 2'b01) begin
            failures++;
            $display("FAIL fatal_dead: got error=%b err_code=%b required 1/01", error, err_code);
        end
        go = 1'b1;
        cyc();
        go = 1'b0;
        cyc();
        checks++;
        if (error !== 1'b1 || bus_if.request !== 1'b0) begin
            failures++;
            $display("FAIL fatal_go_ignored: got error=%b req=%b required 1/0", error, bus_if.request);
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL fatal_clr: got busy=%b error=%b required 0/0", busy, error);
        end
    endtask

    task automatic test_len_boundary();
        issue(1'b1, 32'h0000_5002, 5'd0);
        attempt(1, 40'd0, 32'd0);
        checks++;
        if (addr_seen !== 32'h0000_5000 || beats_done !== 5'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL len0: got addr=%h beats=%0d done=%b required 00005000/1/1",
                     addr_seen, beats_done, done);
        end
        cyc();
        issue(1'b0, 32'h0000_6000, 5'd31);
        attempt(17, 40'd0, 32'd0);
        checks++;
        if (beats_done !== 5'd16 || done !== 1'b1) begin
            failures++;
            $display("FAIL len_clamp: got beats=%0d done=%b required 16/1", beats_done, done);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int d0;
        issue(1'b1, 32'h0000_7000, 5'd4);
        cyc();
        bus_if.m_addr_n = 1'b0;
        cyc();
        bus_if.m_addr_n = 1'b1;
        bus_if.m_data = 1'b1; bus_if.m_data_vld = 1'b1;
        cyc(); cyc();
        reset_n = 1'b0;
        cyc();
        checks++;
        if ({busy, done, error, err_code, rd_valid, beats_done, retry_cnt,
             bus_if.adio_in, bus_if.m_cbe, bus_if.m_wrdn, bus_if.request,
             bus_if.complete, bus_if.m_ready} !== 61'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got busy=%b beats=%0d adio_in=%h cbe=%b wrdn=%b ready=%b required all 0",
                     busy, beats_done, bus_if.adio_in, bus_if.m_cbe, bus_if.m_wrdn, bus_if.m_ready);
        end
        bus_if.m_data = 1'b0; bus_if.m_data_vld = 1'b0;
        reset_n = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_done: got pulses=%0d busy=%b error=%b required 0/0/0",
                     done_cnt - d0, busy, error);
        end
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b0; cmd_dir = 1'b0; cmd_addr = 32'd0; cmd_len = 5'd0; clr = 1'b0;
        bus_if.adio_out = 32'd0; bus_if.m_data = 1'b0; bus_if.m_data_vld = 1'b0;
        bus_if.m_addr_n = 1'b1; bus_if.csr = 40'd0;
        test_reset();
        test_auto_start();
        test_write_burst();
        test_disconnect();
        test_retry_limit();
        test_fatal();
        test_len_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pci_master_seq.md
PCI_MASTER_SEQ -- requirements
Module: pci_master_seq

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- MAX_LEN, 16, maximum beats per transaction (2..256).
- RETRY_MAX, 8, retries allowed before abort (1..255).
- START_DELAY, 31, cycles after reset before the first auto-start (0 disables auto-start).
- AUTO_ADDR, 32'h0000_1000, address used by auto-start.
- WDATA_SEED, 32'hA5A5_0000, write data for beat 0; beat i = WDATA_SEED + i.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK, in, 1, clock, rising-edge.
- reset_n, in, 1, reset, synchronous, active-low.
- go, in, 1, 1-cycle start pulse; ignored unless IDLE.
- cmd_dir, in, 1, direction: 1 = write, 0 = read.
- cmd_addr, in, 32, start byte address; bits[1:0] ignored.
- cmd_len, in, clog2(MAX_LEN)+1, beat count; 0 is treated as 1, and values above MAX_LEN are clamped to MAX_LEN.
- clr, in, 1, leaves DEAD and returns to IDLE.
- adio_out, in, 32, data from the core.
- m_data, in, 1, data phase active.
- m_data_vld, in, 1, a data beat is valid this cycle.
- m_addr_n, in, 1, address phase, active-low.
- csr, in, 40, core status; bits 39/38 are fatal aborts, bit 36 is retry/disconnect.
- adio_in, out, 32, address or write data to the core; driven 0 when not in use (no tri-state).
- m_cbe, out, 4, command or byte enables.
- m_wrdn, out, 1, latched direction.
- request, out, 1, bus request.
- requesthold, out, 1, tied 0.
- complete, out, 1, last-beat indicator.
- m_ready, out, 1, ready.
- busy, out, 1, state is not IDLE.
- done, out, 1, 1-cycle pulse on successful completion.
- error, out, 1, level high while DEAD.
- err_code, out, 2, 01 = fatal, 10 = retry limit.
- rd_data, out, 32, captured read beat.
- rd_valid, out, 1, 1-cycle pulse with rd_data.
- beats_done, out, clog2(MAX_LEN)+1, beats transferred so far.
- retry_cnt, out, 8, retries in the current transaction.

Function
REQ-003 The block SHALL use these states: IDLE, REQ, XFER, RTY, DONE, DEAD.
REQ-004 In IDLE, go or an auto-start (delay counter reaching 0, one time only) SHALL latch dir, addr and len, clear beats_done and retry_cnt, and move to REQ. Auto-start SHALL use a read, AUTO_ADDR and len 1. go SHALL win if both occur in the same cycle.
REQ-005 request SHALL be 1 only in REQ. REQ SHALL move to XFER after exactly 1 cycle.
REQ-006 While m_addr_n = 0, adio_in SHALL equal cur_addr = addr + 4*beats_done, and m_cbe SHALL equal {3'b011, dir}.
REQ-007 Otherwise, m_cbe SHALL equal 4'b0000. adio_in SHALL equal WDATA_SEED + beats_done when dir = 1 and m_data = 1, and 0 in all other cases.
REQ-008 In XFER, each cycle with m_data_vld = 1 SHALL increment beats_done by 1, saturating at len. For reads, the same cycle SHALL register rd_data = adio_out and pulse rd_valid 1 cycle later.
REQ-009 Status flags SHALL be registered as follows.
- fatal and retry SHALL clear when m_addr_n = 0.
- Otherwise, while m_data = 1, fatal SHALL load csr[39] | csr[38] and retry SHALL load csr[36].
REQ-010 m_data_fell SHALL be ~m_data & m_data_q. On m_data_fell in XFER, the priority SHALL be:
- fatal: go to DEAD with err_code 01.
- beats_done == len: go to DONE.
- retry and retry_cnt == RETRY_MAX: go to DEAD with err_code 10.
- otherwise (retry, or disconnect with beats short): go to RTY.
REQ-011 RTY SHALL increment retry_cnt, saturating at 255, and move to REQ after 1 cycle. The transfer SHALL resume at cur_addr with the remaining beats.
REQ-012 DONE SHALL pulse done for 1 cycle and then go to IDLE.
REQ-013 DEAD SHALL hold until clr = 1, then go to IDLE. clr SHALL have no effect in other states.
REQ-014 complete SHALL be registered high when in REQ or XFER and len - beats_done <= 1. It SHALL be low in all other cases.
REQ-015 m_ready SHALL be 0 in the first cycle after reset and 1 thereafter.
REQ-016 m_wrdn SHALL equal the latched dir.

Reset
REQ-017 When reset_n = 0 at a CLK edge, the block SHALL set:
- state = IDLE.
- All outputs = 0 (requesthold = 0).
- beats_done = 0, retry_cnt = 0, err_code = 0.
- Status flags = 0.
- Delay counter = START_DELAY.
REQ-018 A reset asserted mid-transaction SHALL abort the transaction, with no done or error pulse.

Verification
REQ-019 Auto-start: release reset and give no go -> request = 1 at cycle START_DELAY+2, adio_in = 32'h0000_1000 during the address phase, m_cbe = 4'b0110.
REQ-020 Write burst: go with dir = 1, addr = 32'h2000, len = 4; core gives 4 vld beats -> adio_in = A5A50000..A5A50003, done pulses once, beats_done = 4.
REQ-021 Disconnect: read, len = 8; csr[36] = 1 after 3 beats -> RTY, second address phase = 32'h200C, retry_cnt = 1, total rd_valid = 8.
REQ-022 Retry limit: RETRY_MAX = 2; every attempt retried with 0 beats -> DEAD after the 3rd fall, err_code = 10, error = 1 until clr.
REQ-023 Fatal: csr[38] = 1 during data -> DEAD, err_code = 01; clr -> IDLE. go while DEAD -> ignored.
REQ-024 Reset mid-burst: reset_n = 0 on beat 2 -> IDLE, all outputs 0 on the next edge, no done.
